// File: rtl/mem_responder.sv
// Memory-side bus responder: decodes the memory map into zero space, a UART
// (8N1 TX/RX engines) at word 1, and a 16-bit word RAM at word 16 and above.
module mem_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int CLKS_PER_BIT = 16,
  parameter     INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_wr,
  input  logic [15:0]           wr_data,
  output logic [15:0]           rd_data,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  output logic                  tx_busy,
  output logic                  tx_ovf,
  output logic                  rx_ferr
);

  localparam int WORD_W = ADDR_WIDTH - 1;
  localparam int DEPTH  = 1 << WORD_W;
  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  // ---------------------------------------------------------------------------
  // Address decode and bus datapath
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] word_addr;
  logic              uart_sel;
  logic              ram_sel;
  logic [7:0]        rx_byte;

  assign word_addr = mem_addr[ADDR_WIDTH-1:1];
  assign uart_sel  = (word_addr == WORD_W'(1));
  assign ram_sel   = (word_addr >= WORD_W'(16));

  logic [15:0] ram [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  end

  // NOTE: RAM contents are deliberately left out of reset so the array maps
  // onto block RAM; only the output register below is reset.
  always_ff @(posedge clk) begin
    if (mem_wr && ram_sel) ram[word_addr] <= wr_data;
  end

  // NOTE: non-blocking assignments make the read sample the pre-write RAM
  // word and the pre-update rx_byte at the same edge (read-before-write).
  always_ff @(posedge clk) begin
    if (rst)           rd_data <= '0;
    else if (ram_sel)  rd_data <= ram[word_addr];
    else if (uart_sel) rd_data <= {8'hfe, rx_byte};
    else               rd_data <= '0;
  end

  // ---------------------------------------------------------------------------
  // UART transmitter
  // ---------------------------------------------------------------------------
  uart_state_t   tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_wr;
  logic          tx_bit_end;

  assign tx_wr      = mem_wr && uart_sel;
  assign tx_bit_end = (tx_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) tx_state <= S_IDLE;
    else     tx_state <= tx_next;
  end

  // NOTE: next-state defaults to the current state before the case so no
  // path leaves tx_next unassigned and no latch is inferred.
  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      S_IDLE:  if (tx_wr)                          tx_next = S_START;
      S_START: if (tx_bit_end)                     tx_next = S_DATA;
      S_DATA:  if (tx_bit_end && tx_bit == 3'd7)   tx_next = S_STOP;
      S_STOP:  if (tx_bit_end)                     tx_next = S_IDLE;
      default:                                     tx_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_busy = (tx_state != S_IDLE);
    unique case (tx_state)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = tx_shift[0];
      default: uart_tx = 1'b1;
    endcase
  end

  // A write arriving in any non-idle state, including the final STOP cycle,
  // is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_ovf   <= 1'b0;
    end else begin
      if (tx_state == S_IDLE || tx_bit_end) tx_cnt <= '0;
      else                                  tx_cnt <= tx_cnt + CW'(1);
      if (tx_state == S_IDLE && tx_wr) begin
        tx_shift <= wr_data[7:0];
        tx_bit   <= '0;
      end else if (tx_state == S_DATA && tx_bit_end) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
      if (tx_wr && tx_state != S_IDLE) tx_ovf <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  logic          rx_meta, rx_sync, rx_prev;
  logic          rx_fall;
  uart_state_t   rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev && !rx_sync;

  always_ff @(posedge clk) begin
    if (rst) rx_state <= S_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      S_IDLE:  if (rx_fall) rx_next = S_START;
      S_START: if (rx_cnt == HALF_LAST) rx_next = rx_sync ? S_IDLE : S_DATA;
      S_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_next = S_STOP;
      S_STOP:  if (rx_cnt == BIT_LAST) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  // START samples mid-bit to qualify the edge; afterwards every sample lands
  // one full bit later, i.e. on a bit centre.
  always_comb begin
    unique case (rx_state)
      S_START:        rx_sample = (rx_cnt == HALF_LAST);
      S_DATA, S_STOP: rx_sample = (rx_cnt == BIT_LAST);
      default:        rx_sample = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_ferr  <= 1'b0;
    end else begin
      if (rx_state == S_IDLE || rx_sample) rx_cnt <= '0;
      else                                 rx_cnt <= rx_cnt + CW'(1);
      if (rx_state == S_IDLE) rx_bit <= '0;
      if (rx_state == S_DATA && rx_sample) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
      if (rx_state == S_STOP && rx_sample) begin
        if (rx_sync) rx_byte <= rx_shift;
        else         rx_ferr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: RAM, zero space, UART TX
// framing/overflow, UART RX good and bad frames, and mid-frame reset.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  mem_addr;
  logic        mem_wr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        uart_rx;
  logic        uart_tx;
  logic        tx_busy;
  logic        tx_ovf;
  logic        rx_ferr;

  int vectors = 0;
  int errors  = 0;

  mem_responder #(.ADDR_WIDTH(10), .CLKS_PER_BIT(16), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .wr_data(wr_data), .rd_data(rd_data), .uart_rx(uart_rx),
    .uart_tx(uart_tx), .tx_busy(tx_busy), .tx_ovf(tx_ovf), .rx_ferr(rx_ferr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (16) tick();
    end
    uart_rx = stop_bit;
    repeat (16) tick();
    uart_rx = 1'b1;
    repeat (16) tick();
  endtask

  initial begin
    logic [9:0] frame;
    logic [9:0] zero_addrs [3];
    zero_addrs[0] = 10'h000;
    zero_addrs[1] = 10'h010;
    zero_addrs[2] = 10'h01e;

    rst = 1'b1; mem_addr = '0; mem_wr = 1'b0; wr_data = '0; uart_rx = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_rd_data", rd_data, 16'h0000);
    check("rst_uart_tx", {15'd0, uart_tx}, 16'd1);
    check("rst_tx_busy", {15'd0, tx_busy}, 16'd0);
    check("rst_tx_ovf",  {15'd0, tx_ovf},  16'd0);
    check("rst_rx_ferr", {15'd0, rx_ferr}, 16'd0);

    // RAM write then read, neighbour untouched
    mem_addr = 10'h040; mem_wr = 1'b1; wr_data = 16'h1234;
    tick();
    mem_wr = 1'b0;
    tick();
    check("ram_rd_0040", rd_data, 16'h1234);
    mem_addr = 10'h042;
    tick();
    check("ram_rd_0042", rd_data, 16'h0000);

    // Read-before-write on the same edge
    mem_addr = 10'h040; mem_wr = 1'b1; wr_data = 16'habcd;
    tick();
    check("ram_rbw_old", rd_data, 16'h1234);
    mem_wr = 1'b0;
    tick();
    check("ram_rbw_new", rd_data, 16'habcd);

    // Unmapped space ignores writes and reads zero
    foreach (zero_addrs[i]) begin
      mem_addr = zero_addrs[i]; mem_wr = 1'b1; wr_data = 16'hffff;
      tick();
      mem_wr = 1'b0;
      tick();
      check($sformatf("zero_rd_%03h", zero_addrs[i]), rd_data, 16'h0000);
    end

    // TX frame of 55h, with a dropped second write at cycle 20
    frame = {1'b1, 8'h55, 1'b0};
    mem_addr = 10'h002; mem_wr = 1'b1; wr_data = 16'h0055;
    tick();
    mem_wr = 1'b0;
    for (int k = 0; k <= 160; k++) begin
      if (k < 160) begin
        check($sformatf("tx_line_k%0d", k), {15'd0, uart_tx}, {15'd0, frame[k/16]});
      end else begin
        check("tx_line_idle", {15'd0, uart_tx}, 16'd1);
      end
      if (k == 0 || k == 159 || k == 160)
        check($sformatf("tx_busy_k%0d", k), {15'd0, tx_busy}, (k < 160) ? 16'd1 : 16'd0);
      if (k == 19) begin
        check("tx_ovf_before", {15'd0, tx_ovf}, 16'd0);
        mem_wr = 1'b1; wr_data = 16'h00aa;
      end
      if (k == 20) begin
        check("tx_ovf_set", {15'd0, tx_ovf}, 16'd1);
        mem_wr = 1'b0;
      end
      if (k < 160) tick();
    end

    // RX good frame A5h
    send_frame(8'ha5, 1'b1);
    mem_addr = 10'h002;
    tick();
    check("rx_rd_a5", rd_data, 16'hfea5);
    check("rx_ferr_clear", {15'd0, rx_ferr}, 16'd0);

    // RX frame with stop bit 0: byte kept, ferr set
    send_frame(8'h3c, 1'b0);
    tick();
    check("rx_ferr_set", {15'd0, rx_ferr}, 16'd1);
    check("rx_rd_kept", rd_data, 16'hfea5);

    // Reset in the middle of TX data bit 4
    mem_addr = 10'h002; mem_wr = 1'b1; wr_data = 16'h0081;
    tick();
    mem_wr = 1'b0;
    repeat (88) tick();
    check("mid_tx_busy", {15'd0, tx_busy}, 16'd1);
    check("mid_tx_bit4", {15'd0, uart_tx}, 16'd0);
    rst = 1'b1; mem_addr = 10'h040;
    tick();
    check("rst_mid_uart_tx", {15'd0, uart_tx}, 16'd1);
    check("rst_mid_tx_busy", {15'd0, tx_busy}, 16'd0);
    check("rst_mid_rd_data", rd_data, 16'h0000);
    check("rst_mid_tx_ovf",  {15'd0, tx_ovf},  16'd0);
    check("rst_mid_rx_ferr", {15'd0, rx_ferr}, 16'd0);
    rst = 1'b0;
    tick();
    check("ram_after_rst", rd_data, 16'habcd);
    repeat (20) tick();
    check("tx_stays_idle", {15'd0, uart_tx}, 16'd1);
    check("tx_busy_idle",  {15'd0, tx_busy}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
